// File: rtl/hwpe_stream_load_reqgen_pkg.sv
// hwpe_stream_load_reqgen_pkg: shared types for the load request generator
package hwpe_stream_load_reqgen_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} load_reqgen_state_t;

    typedef struct packed {
        logic [31:0] trans_size;
    } ctrl_load_reqgen_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_load_reqgen_t;

endpackage

// File: rtl/hwpe_stream_load_respbuf.sv
// hwpe_stream_load_respbuf: response FIFO whose outputs come straight from registers
module hwpe_stream_load_respbuf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [CW-1:0]         count_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push_i) begin
                mem[wptr] <= data_i;
                wptr      <= wptr + 1'b1;
            end
            if (pop_i) rptr <= rptr + 1'b1;
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    assign valid_o = count_o != '0;
    assign data_o  = mem[rptr];

    // the credit scheme upstream must make a push into a full buffer impossible
    assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        !(push_i && !pop_i && count_o == CW'(DEPTH)));

endmodule

// File: rtl/hwpe_stream_load_reqgen.sv
// hwpe_stream_load_reqgen: credit-bounded TCDM read issuer returning data as a stream
module hwpe_stream_load_reqgen
    import hwpe_stream_load_reqgen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned CNT         = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT-1:0]          trans_size_i,
    input  logic [31:0]             addr_i,
    output logic                    addr_enable_o,
    output logic                    tcdm_req_o,
    output logic [31:0]             tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    input  logic                    tcdm_gnt_i,
    input  logic                    tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    output logic                    stream_valid_o,
    output logic [DATA_WIDTH-1:0]   stream_data_o,
    input  logic                    stream_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

    load_reqgen_state_t state, state_next;
    flags_load_reqgen_t flags;
    logic [CNT-1:0]     size, issued_cnt, consumed_cnt;
    logic [CW-1:0]      buf_count;
    logic               inflight, grant, pop, done_q, done_next;

    // a granted read not yet landed in the buffer still holds a credit
    assign tcdm_req_o    = state == ISSUE && !clear_i &&
                           (buf_count + CW'(inflight)) < CW'(OUTSTANDING);
    assign grant         = tcdm_req_o & tcdm_gnt_i;
    assign addr_enable_o = grant;
    assign tcdm_add_o    = addr_i & 32'hFFFF_FFFC;
    assign tcdm_wen_o    = 1'b1;
    assign tcdm_be_o     = '1;
    assign pop           = stream_valid_o & stream_ready_i;
    assign flags         = '{busy: state != IDLE, done: done_q};
    assign busy_o        = flags.busy;
    assign done_o        = flags.done;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = trans_size_i != '0 ? ISSUE : IDLE;
                    done_next  = trans_size_i == '0;
                end
            end
            ISSUE: begin
                if (grant && issued_cnt + CNT'(1) == size) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && consumed_cnt + CNT'(1) == size) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= IDLE;
            size         <= '0;
            issued_cnt   <= '0;
            consumed_cnt <= '0;
            inflight     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= grant;
            done_q   <= done_next;
            if (state == IDLE && start_i && trans_size_i != '0) begin
                size         <= trans_size_i;
                issued_cnt   <= '0;
                consumed_cnt <= '0;
            end else begin
                if (grant) issued_cnt <= issued_cnt + CNT'(1);
                if (pop) consumed_cnt <= consumed_cnt + CNT'(1);
            end
        end
    end

    hwpe_stream_load_respbuf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (OUTSTANDING),
        .CW        (CW)
    ) u_respbuf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear_i),
        .push_i (tcdm_r_valid_i),
        .data_i (tcdm_r_data_i),
        .pop_i  (pop),
        .data_o (stream_data_o),
        .valid_o(stream_valid_o),
        .count_o(buf_count)
    );

endmodule

// File: tb/tb_hwpe_stream_load_reqgen.sv
// tb_hwpe_stream_load_reqgen: directed scenarios with a one-cycle-latency TCDM and address generator model
module tb_hwpe_stream_load_reqgen;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] trans_size_i = '0;
    logic [31:0] addr_i = '0;
    logic        addr_enable_o;
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt_i = 1'b0;
    logic        tcdm_r_valid_i = 1'b0;
    logic [31:0] tcdm_r_data_i = '0;
    logic        stream_valid_o;
    logic [31:0] stream_data_o;
    logic        stream_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int failures = 0;
    int grants = 0;
    int dones = 0;
    int max_count = 0;
    logic [31:0] got [$];

    hwpe_stream_load_reqgen #(.DATA_WIDTH(32), .OUTSTANDING(4), .CNT(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .trans_size_i  (trans_size_i),
        .addr_i        (addr_i),
        .addr_enable_o (addr_enable_o),
        .tcdm_req_o    (tcdm_req_o),
        .tcdm_add_o    (tcdm_add_o),
        .tcdm_wen_o    (tcdm_wen_o),
        .tcdm_be_o     (tcdm_be_o),
        .tcdm_gnt_i    (tcdm_gnt_i),
        .tcdm_r_valid_i(tcdm_r_valid_i),
        .tcdm_r_data_i (tcdm_r_data_i),
        .stream_valid_o(stream_valid_o),
        .stream_data_o (stream_data_o),
        .stream_ready_i(stream_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    // memory returns the granted address as data; address generator steps by 4 on enable
    always @(posedge clk) begin
        tcdm_r_valid_i <= tcdm_req_o & tcdm_gnt_i;
        tcdm_r_data_i  <= tcdm_add_o;
        if (rst_i || clear_i || (start_i && !busy_o)) addr_i <= '0;
        else if (addr_enable_o) addr_i <= addr_i + 32'd4;
        if (!rst_i && !clear_i && stream_valid_o && stream_ready_i) got.push_back(stream_data_o);
        if (tcdm_req_o && tcdm_gnt_i) grants++;
        if (done_o) dones++;
        if (int'(dut.buf_count) > max_count) max_count <= int'(dut.buf_count);
    end

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start_i = 1'b1;
        trans_size_i = n;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (dones > d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (tcdm_req_o !== 1'b0 || addr_enable_o !== 1'b0 || stream_valid_o !== 1'b0 ||
            busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b en=%b valid=%b busy=%b done=%b expected all 0",
                     tcdm_req_o, addr_enable_o, stream_valid_o, busy_o, done_o);
        end
        checks++;
        if (stream_data_o !== 32'h0 || tcdm_wen_o !== 1'b1 || tcdm_be_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_data: data=%h wen=%b be=%h expected 0/1/f",
                     stream_data_o, tcdm_wen_o, tcdm_be_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int d0, g0, n0;
        bit ok;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b1;
        d0 = dones; g0 = grants; n0 = got.size();
        do_start(16'd4);
        #1;
        checks++;
        if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h0 || addr_enable_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_req: req=%b add=%h en=%b busy=%b expected 1/0/1/1",
                     tcdm_req_o, tcdm_add_o, addr_enable_o, busy_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stream_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency_early: valid=%b expected 0", stream_valid_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stream_valid_o !== 1'b1 || stream_data_o !== 32'h0) begin
            failures++;
            $display("FAIL basic_first_beat: valid=%b data=%h expected 1/0", stream_valid_o, stream_data_o);
        end
        wait_done(d0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_done_timeout: done not seen expected pulse");
        end
        checks++;
        if (grants - g0 != 4 || dones - d0 != 1 || busy_o !== 1'b0 || got.size() - n0 != 4) begin
            failures++;
            $display("FAIL basic_counts: grants=%0d dones=%0d busy=%b beats=%0d expected 4/1/0/4",
                     grants - g0, dones - d0, busy_o, got.size() - n0);
        end
        for (int i = 0; i < 4 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0 + i] !== 32'(4 * i)) begin
                failures++;
                $display("FAIL basic_beat%0d: got=%h expected %h", i, got[n0 + i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_gnt_stall;
        int d0, n0;
        bit ok;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b1;
        d0 = dones; n0 = got.size();
        do_start(16'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tcdm_gnt_i = i == 3;
            #1;
            checks++;
            if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h4 || addr_enable_o !== (i == 3)) begin
                failures++;
                $display("FAIL stall_hold%0d: req=%b add=%h en=%b expected 1/4/%0d",
                         i, tcdm_req_o, tcdm_add_o, addr_enable_o, i == 3);
            end
        end
        wait_done(d0, ok);
        checks++;
        if (!ok || got.size() - n0 != 4) begin
            failures++;
            $display("FAIL stall_done: done=%b beats=%0d expected 1/4", ok, got.size() - n0);
        end
        for (int i = 0; i < 4 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0 + i] !== 32'(4 * i)) begin
                failures++;
                $display("FAIL stall_beat%0d: got=%h expected %h", i, got[n0 + i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure;
        int d0, g0, n0;
        bit ok;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b0;
        d0 = dones; g0 = grants; n0 = got.size();
        do_start(16'd8);
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (grants - g0 != 4 || tcdm_req_o !== 1'b0 || got.size() != n0) begin
            failures++;
            $display("FAIL bp_credit: grants=%0d req=%b beats=%0d expected 4/0/0",
                     grants - g0, tcdm_req_o, got.size() - n0);
        end
        checks++;
        if (stream_valid_o !== 1'b1 || stream_data_o !== 32'h0) begin
            failures++;
            $display("FAIL bp_hold: valid=%b data=%h expected 1/0", stream_valid_o, stream_data_o);
        end
        stream_ready_i = 1'b1;
        wait_done(d0, ok);
        checks++;
        if (!ok || grants - g0 != 8 || got.size() - n0 != 8) begin
            failures++;
            $display("FAIL bp_done: done=%b grants=%0d beats=%0d expected 1/8/8",
                     ok, grants - g0, got.size() - n0);
        end
        for (int i = 0; i < 8 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0 + i] !== 32'(4 * i)) begin
                failures++;
                $display("FAIL bp_beat%0d: got=%h expected %h", i, got[n0 + i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_zero;
        int g0;
        g0 = grants;
        tcdm_gnt_i = 1'b1;
        do_start(16'd0);
        #1;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: done=%b busy=%b req=%b expected 1/0/0", done_o, busy_o, tcdm_req_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || grants != g0) begin
            failures++;
            $display("FAIL zero_after: done=%b busy=%b grants=%0d expected 0/0/0", done_o, busy_o, grants - g0);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear;
        int d0, g0, n0;
        bit ok;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b1;
        d0 = dones; g0 = grants;
        do_start(16'd8);
        repeat (3) @(negedge clk);
        clear_i = 1'b1;
        #1;
        checks++;
        if (tcdm_req_o !== 1'b0 || tcdm_r_valid_i !== 1'b1 || grants - g0 != 3) begin
            failures++;
            $display("FAIL clear_cycle: req=%b rvalid=%b grants=%0d expected 0/1/3",
                     tcdm_req_o, tcdm_r_valid_i, grants - g0);
        end
        @(negedge clk);
        clear_i = 1'b0;
        #1;
        checks++;
        if (tcdm_req_o !== 1'b0 || stream_valid_o !== 1'b0 || busy_o !== 1'b0 || stream_data_o !== 32'h0) begin
            failures++;
            $display("FAIL clear_after: req=%b valid=%b busy=%b data=%h expected 0/0/0/0",
                     tcdm_req_o, stream_valid_o, busy_o, stream_data_o);
        end
        checks++;
        if (dones != d0) begin
            failures++;
            $display("FAIL clear_no_done: dones=%0d expected 0", dones - d0);
        end
        n0 = got.size();
        do_start(16'd2);
        wait_done(d0, ok);
        checks++;
        if (!ok || got.size() - n0 != 2 || dones - d0 != 1) begin
            failures++;
            $display("FAIL clear_restart: done=%b beats=%0d dones=%0d expected 1/2/1",
                     ok, got.size() - n0, dones - d0);
        end
        for (int i = 0; i < 2 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0 + i] !== 32'(4 * i)) begin
                failures++;
                $display("FAIL clear_beat%0d: got=%h expected %h", i, got[n0 + i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_full_pushpop;
        int d0, n0;
        bit ok;
        tcdm_gnt_i = 1'b1;
        stream_ready_i = 1'b0;
        d0 = dones; n0 = got.size();
        do_start(16'd8);
        repeat (4) @(negedge clk);
        stream_ready_i = 1'b1;
        #1;
        checks++;
        if (dut.buf_count !== 3'd3 || tcdm_r_valid_i !== 1'b1 || stream_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL full_setup: count=%0d rvalid=%b valid=%b expected 3/1/1",
                     dut.buf_count, tcdm_r_valid_i, stream_valid_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.buf_count !== 3'd3 || tcdm_req_o !== 1'b1) begin
            failures++;
            $display("FAIL full_pushpop: count=%0d req=%b expected 3/1", dut.buf_count, tcdm_req_o);
        end
        wait_done(d0, ok);
        checks++;
        if (!ok || got.size() - n0 != 8 || max_count > 4) begin
            failures++;
            $display("FAIL full_done: done=%b beats=%0d max_count=%0d expected 1/8/<=4",
                     ok, got.size() - n0, max_count);
        end
        for (int i = 0; i < 8 && n0 + i < got.size(); i++) begin
            checks++;
            if (got[n0 + i] !== 32'(4 * i)) begin
                failures++;
                $display("FAIL full_beat%0d: got=%h expected %h", i, got[n0 + i], 32'(4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_backpressure();
        test_zero();
        test_clear();
        test_full_pushpop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_load_reqgen.md
Name: hwpe_stream_load_reqgen

Overview:
- Load-side request engine placed directly downstream of the address generator.
- Consumes one generated word address per cycle and issues word-aligned TCDM read requests with the req/gnt handshake.
- Returns the read data as a valid/ready stream to the datapath.
- Bounds in-flight reads with a credit scheme so a stalled consumer never loses a response. It drives the address generator's enable so addresses advance only on granted requests.

Parameters:
- DATA_WIDTH, 32, TCDM/stream data width in bits (multiple of 8).
- OUTSTANDING, 4, response buffer depth = maximum reads granted but not yet consumed (power of 2, ≥2).
- CNT, 16, width of the transaction counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as reset
- start_i  in  1  start pulse; sampled only in IDLE
- trans_size_i  in  CNT  number of words to load; latched on start
- addr_i  in  32  word address from address generator, low 2 bits ignored
- addr_enable_o  out  1  advance address generator (= tcdm_req_o & tcdm_gnt_i)
- tcdm_req_o  out  1  read request
- tcdm_add_o  out  32  {addr_i[31:2],2'b0}
- tcdm_wen_o  out  1  constant 1 (read)
- tcdm_be_o  out  DATA_WIDTH/8  constant all ones
- tcdm_gnt_i  in  1  grant
- tcdm_r_valid_i  in  1  response valid, exactly 1 cycle after gnt
- tcdm_r_data_i  in  DATA_WIDTH  response data
- stream_valid_o  out  1  output stream valid
- stream_data_o  out  DATA_WIDTH  output stream data
- stream_ready_i  in  1  output stream ready
- busy_o  out  1  high in ISSUE or DRAIN
- done_o  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset/clear values:
  - FSM returns to IDLE.
  - Counters and buffer are emptied.
  - tcdm_req_o=0, addr_enable_o=0, stream_valid_o=0, busy_o=0, done_o=0.
  - stream_data_o=0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On start_i with trans_size_i>0: latch size, clear issued_cnt and consumed_cnt, go to ISSUE.
  - On start_i with trans_size_i==0: stay in IDLE and pulse done_o in the next cycle.
- ISSUE:
  - tcdm_req_o = (buf_count + inflight) < OUTSTANDING.
  - inflight is a 1-bit register set by the previous cycle's req&gnt.
  - On req&gnt, issued_cnt increments.
  - When the grant makes issued_cnt == size, go to DRAIN in the next cycle. No request is raised after that.
  - A request stays asserted with a stable address until granted; the address generator holds because addr_enable_o=0.
- DRAIN:
  - tcdm_req_o=0.
  - When consumed_cnt reaches size (final accepted beat), go to IDLE and pulse done_o in the same transition cycle +1 (registered).
- Response path:
  - tcdm_r_valid_i pushes tcdm_r_data_i into the buffer.
  - The buffer output is registered, so a grant at cycle T gives stream_valid_o at T+2 at the earliest.
  - Pop occurs on stream_valid_o & stream_ready_i; each pop increments consumed_cnt.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit check guarantees no push into a full buffer. An overflow is an assertion failure.
- Valid/ready rules:
  - stream_valid_o never drops without a handshake.
  - stream_data_o is stable while valid & !ready.
- Clear mid-operation:
  - tcdm_req_o is forced 0 in the clear cycle.
  - An r_valid arriving in the clear cycle (grant in the previous cycle) is discarded.
  - No done_o pulse.
- Arithmetic: counters are CNT-bit unsigned; size up to 2^CNT-1; no wrap within a transfer.
- start_i is ignored outside IDLE.

Decomposition:
- hwpe_stream_package additions:
  - load_reqgen_state_t enum {IDLE, ISSUE, DRAIN}.
  - ctrl_load_reqgen_t {trans_size}.
  - flags_load_reqgen_t {busy, done}.
- Sub-module hwpe_stream_load_respbuf:
  - OUTSTANDING-deep synchronous FIFO with registered output and count output.
  - Push/pop/clear ports; same clk_i/rst_i convention.

Test Plan:
- Basic load: trans_size=4, gnt always 1, ready always 1, r_data = address → 4 requests in consecutive cycles; stream beats 0x0,0x4,0x8,0xC starting 2 cycles after the first grant; done_o pulses once; busy_o low afterwards.
- Grant stalls: gnt low for 3 cycles on the second request → tcdm_add_o held constant and addr_enable_o=0 during the stall; 4 beats delivered in order.
- Consumer backpressure: ready=0 for 10 cycles, size=8, OUTSTANDING=4 → exactly 4 grants then req stays low; no data lost; remaining 4 issue after ready rises; 8 beats total.
- Zero size: start_i with trans_size_i=0 → no tcdm_req_o; done_o one cycle later; busy_o never high.
- Clear mid-transfer: size=8; assert clear_i after 3 grants with r_valid active in the clear cycle → next cycle req=0, stream_valid_o=0, IDLE; a following start with size=2 delivers exactly 2 correct beats.
- Simultaneous push/pop at full: buffer at 3 entries, r_valid and pop in the same cycle → count stays 3; never exceeds 4 (assertion).
